// File: rtl/data_selector_pkg.sv
`default_nettype none
// data_selector_pkg: shared widths, entry field offsets and controller state encoding.
// Rev 1.0
package data_selector_pkg;

  localparam int NUM_OUTPUTS   = 16;
  localparam int MAIN_SEL_BITS = 4;
  localparam int REGS_SEL_BITS = 6;
  localparam int ENTRY_BITS    = 1 + MAIN_SEL_BITS + REGS_SEL_BITS;
  localparam int INDEX_BITS    = $clog2(NUM_OUTPUTS);
  localparam int SEL_BUS_BITS  = NUM_OUTPUTS * ENTRY_BITS;

  localparam int ORIGIN_BIT = 0;
  localparam int MAIN_LSB   = 1;
  localparam int REGS_LSB   = 5;

  typedef logic [ENTRY_BITS-1:0] entry_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HOLD = 3'd1,
    ST_SWAP      = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_ACK       = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/selector_cfg_table.sv
`default_nettype none
// selector_cfg_table: double-buffered shadow/active selection table with flattened output.
// Rev 1.0
module selector_cfg_table
  import data_selector_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_index,
  input  logic [ENTRY_BITS-1:0]   wr_entry,
  input  logic                    swap,
  output logic [SEL_BUS_BITS-1:0] sel_bus
);

  entry_t shadow [NUM_OUTPUTS];
  entry_t active [NUM_OUTPUTS];

  // Writes only happen while idle and swaps only in the swap state, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_index] <= wr_entry;
      end
      if (swap) begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_flat
      assign sel_bus[g*ENTRY_BITS +: ENTRY_BITS] = active[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/data_selector_cfg_ctrl.sv
`default_nettype none
// data_selector_cfg_ctrl: host-loaded selection table with hold-aware atomic commit and busy/settle window.
// Rev 1.0
module data_selector_cfg_ctrl
  import data_selector_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [INDEX_BITS-1:0]   cfg_index,
  input  logic [ENTRY_BITS-1:0]   cfg_entry,
  input  logic                    commit_req,
  output logic                    commit_ack,
  input  logic                    hold,
  output logic                    dirty,
  output logic [SEL_BUS_BITS-1:0] wSelec,
  output logic                    wBusy
);

  localparam int CNT_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(SETTLE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  state_t              state;
  logic [CNT_BITS-1:0] settle_cnt;
  logic                write_en;
  logic                swap;

  assign write_en = cfg_valid && cfg_ready;
  assign swap     = (state == ST_SWAP);

  selector_cfg_table u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (write_en),
    .wr_index (cfg_index),
    .wr_entry (cfg_entry),
    .swap     (swap),
    .sel_bus  (wSelec)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      cfg_ready  <= 1'b0;
      commit_ack <= 1'b0;
      wBusy      <= 1'b0;
      dirty      <= 1'b0;
    end else begin
      commit_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          cfg_ready <= 1'b1;
          if (write_en) begin
            dirty <= 1'b1;
          end
          // A write landing in the same cycle as the commit is part of this swap.
          if (commit_req) begin
            cfg_ready <= 1'b0;
            if (!dirty && !write_en) begin
              state      <= ST_ACK;
              commit_ack <= 1'b1;
            end else if (hold) begin
              state <= ST_WAIT_HOLD;
            end else begin
              state <= ST_SWAP;
              wBusy <= 1'b1;
            end
          end
        end
        ST_WAIT_HOLD: begin
          if (!hold) begin
            state <= ST_SWAP;
            wBusy <= 1'b1;
          end
        end
        ST_SWAP: begin
          dirty      <= 1'b0;
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == CNT_LAST) begin
            wBusy      <= 1'b0;
            commit_ack <= 1'b1;
            state      <= ST_ACK;
          end else begin
            settle_cnt <= settle_cnt + CNT_ONE;
          end
        end
        ST_ACK: begin
          cfg_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b0;
          wBusy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
